// File: rtl/inst_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
package inst_ram_loader_pkg;

    localparam int          WORD_W = 32;
    localparam int          ADDR_W = 12;
    localparam logic [3:0]  WE_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        VERIFY,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/inst_ram_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from an accepted byte stream.
module byte_packer
    import inst_ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Shift right so the first byte of a group ends up in bits [7:0].
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            word_d = {byte_data_i, word_q[WORD_W-1:8]};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_ram_loader.sv
// Streams bytes into an instruction RAM, then reads it back and compares checksums.
module inst_ram_loader
    import inst_ram_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int BASE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [11:0]       word_count,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [WORD_W-1:0] ram_dina,
    input  logic [WORD_W-1:0] ram_douta,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] load_sum
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [WORD_W-1:0] load_sum_q, load_sum_d;
    logic [WORD_W-1:0] read_sum_q, read_sum_d;
    logic              error_q, error_d;

    logic              pk_clear;
    logic              pk_ready;
    logic [WORD_W-1:0] pk_word;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_idx;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pk_clear),
        .byte_valid_i (s_valid && s_ready),
        .byte_data_i  (s_data),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            index_q    <= '0;
            load_sum_q <= '0;
            read_sum_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            load_sum_q <= load_sum_d;
            read_sum_q <= read_sum_d;
            error_q    <= error_d;
        end
    end

    assign cur_addr = BASE_A + index_q;
    assign last_idx = ({1'b0, index_q} + 13'd1) >= {1'b0, count_q};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        load_sum_d = load_sum_q;
        read_sum_d = read_sum_q;
        error_d    = error_q;
        pk_clear   = 1'b0;
        s_ready    = 1'b0;
        ram_wea    = '0;
        ram_addra  = '0;
        ram_dina   = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_d = DONE;
                        error_d = 1'b0;
                    end else if ({1'b0, word_count} > DEPTH_W) begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d    = COLLECT;
                        count_d    = word_count;
                        index_d    = '0;
                        load_sum_d = '0;
                        read_sum_d = '0;
                        error_d    = 1'b0;
                        pk_clear   = 1'b1;
                    end
                end
            end
            COLLECT: begin
                s_ready = 1'b1;
                if (pk_ready) state_d = WRITE;
            end
            WRITE: begin
                ram_wea    = WE_ALL;
                ram_addra  = cur_addr;
                ram_dina   = pk_word;
                load_sum_d = load_sum_q + pk_word;
                if (last_idx) begin
                    index_d = '0;
                    state_d = VERIFY;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = COLLECT;
                end
            end
            VERIFY: begin
                // RAM read is registered: data seen now belongs to the previous address.
                ram_addra = cur_addr;
                if (index_q != '0) read_sum_d = read_sum_q + ram_douta;
                index_d = index_q + 1'b1;
                if (last_idx) state_d = CHECK;
            end
            CHECK: begin
                read_sum_d = read_sum_q + ram_douta;
                error_d    = (read_sum_d != load_sum_q);
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign error    = error_q;
    assign load_sum = load_sum_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Scoreboard bench for inst_ram_loader with a behavioural registered-read RAM.
module tb_inst_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [3:0]  ram_wea;
    logic [11:0] ram_addra;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_sum;

    int total = 0;
    int bad   = 0;
    int wea_cnt;
    int sready_cnt;
    bit flip_w1;

    logic [31:0] mem [4096];
    logic [43:0] exp_q [$];
    logic [7:0]  tx_q [$];
    int          gap_q [$];

    inst_ram_loader #(.DEPTH(1024), .BASE(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_douta  (ram_douta),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .load_sum   (load_sum)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; optionally corrupts bit 0 of word 1 on readback.
    always @(posedge clk) begin
        ram_douta <= mem[ram_addra] ^ ((flip_w1 && ram_addra == 12'd1) ? 32'd1 : 32'd0);
        if (ram_wea == 4'hF) mem[ram_addra] <= ram_dina;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected {addr,data} entry.
    always @(negedge clk) begin
        if (s_ready) sready_cnt++;
        if (ram_wea != 4'h0) begin
            logic [43:0] e;
            wea_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addra, ram_dina);
            end else begin
                e = exp_q.pop_front();
                chk("wr_wea", {28'd0, ram_wea}, 32'hF);
                chk("wr_addr", {20'd0, ram_addra}, {20'd0, e[43:32]});
                chk("wr_data", ram_dina, e[31:0]);
            end
        end
    end

    task automatic do_start(input logic [11:0] wc);
        @(negedge clk);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Sends tx_q; gap_q[i] idle cycles precede byte i (missing entries mean no gap).
    task automatic send_bytes();
        int budget;
        for (int i = 0; i < tx_q.size(); i++) begin
            int g = (i < gap_q.size()) ? gap_q[i] : 0;
            for (int k = 0; k < g; k++) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            budget = 0;
            while (!s_ready && budget < 50) begin
                s_valid = 1'b0;
                @(negedge clk);
                budget++;
            end
            if (!s_ready) begin
                total++;
                bad++;
                $display("FAIL sready_timeout: got s_ready=0 expected 1 for byte %0d", i);
                return;
            end
            s_valid = 1'b1;
            s_data  = tx_q[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic load_std_stream();
        tx_q = '{8'h93, 8'h46, 8'h00, 8'h40, 8'h37, 8'h11, 8'h00, 8'h00};
        exp_q.push_back({12'd0, 32'h40004693});
        exp_q.push_back({12'd1, 32'h00001137});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; word_count = '0;
        s_valid = 1'b0; s_data = '0; flip_w1 = 1'b0;
        wea_cnt = 0; sready_cnt = 0;
        repeat (3) @(negedge clk);

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_wea", {28'd0, ram_wea}, 32'd0);
        chk("rst_addr", {20'd0, ram_addra}, 32'd0);
        chk("rst_dina", ram_dina, 32'd0);
        chk("rst_sready", {31'd0, s_ready}, 32'd0);
        chk("rst_sum", load_sum, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load test
        wea_cnt = 0;
        load_std_stream();
        gap_q = {};
        do_start(12'd2);
        send_bytes();
        wait_done("load");
        chk("load_error", {31'd0, error}, 32'd0);
        chk("load_sum", load_sum, 32'h400057CA);
        chk("load_wea_cnt", wea_cnt, 2);
        chk("load_q_empty", exp_q.size(), 0);
        chk("load_busy", {31'd0, busy}, 32'd0);

        // Stall test
        wea_cnt = 0;
        mem[0] = '0; mem[1] = '0;
        load_std_stream();
        gap_q = '{1, 2, 0, 3, 4, 0, 1, 2};
        do_start(12'd2);
        send_bytes();
        wait_done("stall");
        chk("stall_error", {31'd0, error}, 32'd0);
        chk("stall_sum", load_sum, 32'h400057CA);
        chk("stall_wea_cnt", wea_cnt, 2);
        chk("stall_mem0", mem[0], 32'h40004693);
        chk("stall_mem1", mem[1], 32'h00001137);

        // Empty test
        wea_cnt = 0;
        do_start(12'd0);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_error", {31'd0, error}, 32'd0);
        repeat (3) @(negedge clk);
        chk("empty_wea_cnt", wea_cnt, 0);

        // Corruption test
        wea_cnt = 0;
        flip_w1 = 1'b1;
        load_std_stream();
        gap_q = {};
        do_start(12'd2);
        send_bytes();
        wait_done("corrupt");
        chk("corrupt_error", {31'd0, error}, 32'd1);
        chk("corrupt_wea_cnt", wea_cnt, 2);
        flip_w1 = 1'b0;

        // Reset mid-load after three bytes
        tx_q = '{8'hAA, 8'hBB, 8'hCC};
        gap_q = {};
        do_start(12'd2);
        send_bytes();
        rst_n = 1'b0;
        #1;
        chk("midrst_wea", {28'd0, ram_wea}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_sready", {31'd0, s_ready}, 32'd0);
        chk("midrst_sum", load_sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wea_cnt = 0;
        tx_q = '{8'h6F, 8'h00, 8'h00, 8'h00};
        exp_q.push_back({12'd0, 32'h0000006F});
        do_start(12'd1);
        send_bytes();
        wait_done("postrst");
        chk("postrst_error", {31'd0, error}, 32'd0);
        chk("postrst_sum", load_sum, 32'h0000006F);
        chk("postrst_wea_cnt", wea_cnt, 1);

        // Illegal count
        wea_cnt = 0;
        sready_cnt = 0;
        do_start(12'd1025);
        chk("illegal_done", {31'd0, done}, 32'd1);
        chk("illegal_error", {31'd0, error}, 32'd1);
        repeat (5) @(negedge clk);
        chk("illegal_wea_cnt", wea_cnt, 0);
        chk("illegal_sready_cnt", sready_cnt, 0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
